// File: rtl/signed_pow2_divider_seq.sv
// Iterative signed divide by 2^k with floor or truncate-toward-zero rounding, STEP bits per cycle.
// Optional remainder output enabled by defining SIGNED_POW2_DIVIDER_REMAINDER_EN.
module signed_pow2_divider_seq #(
  parameter int N    = 8,
  parameter int STEP = 1,
  parameter int SW   = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shift,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
`ifdef SIGNED_POW2_DIVIDER_REMAINDER_EN
  ,
  output logic [N-1:0]  out_rem
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SW-1:0] N_SW    = SW'(N);
  localparam logic [SW-1:0] STEP_SW = SW'(STEP);

  state_t        state;
  logic [N-1:0]  acc;
  logic [SW-1:0] cnt;
  logic          mode;
  logic          sign;
  logic          sticky;

  logic [SW-1:0] in_k;
  logic [SW-1:0] k_step;
  logic [SW-1:0] cnt_next;
  logic [N-1:0]  acc_shift;
  logic [N-1:0]  lost_mask;
  logic [N-1:0]  acc_final;
  logic          sticky_next;
  logic          round_up;

  assign in_ready = (state == IDLE);

  // NOTE: every signal driven here is assigned unconditionally, so no latch can be inferred.
  always_comb begin
    in_k        = (in_shift > N_SW) ? N_SW : in_shift;
    k_step      = (cnt > STEP_SW) ? STEP_SW : cnt;
    acc_shift   = $signed(acc) >>> k_step;
    lost_mask   = ~({N{1'b1}} << k_step);
    sticky_next = sticky | (|(acc & lost_mask));
    cnt_next    = cnt - k_step;
    round_up    = mode && sign && sticky_next;
    acc_final   = round_up ? acc_shift + N'(1) : acc_shift;
  end

`ifdef SIGNED_POW2_DIVIDER_REMAINDER_EN
  logic [N-1:0]  data_q;
  logic [SW-1:0] k_q;
  logic [N-1:0]  rem_floor;
  logic [N-1:0]  rem_next;

  // Floor remainder is the low k bits; a rounded-up quotient removes one 2^k (which wraps to 0 at k=N).
  always_comb begin
    rem_floor = data_q & ~({N{1'b1}} << k_q);
    rem_next  = round_up ? rem_floor - (N'(1) << k_q) : rem_floor;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      mode      <= 1'b0;
      sign      <= 1'b0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef SIGNED_POW2_DIVIDER_REMAINDER_EN
      data_q    <= '0;
      k_q       <= '0;
      out_rem   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= in_data;
            cnt    <= in_k;
            mode   <= in_mode;
            sign   <= in_data[N-1];
            sticky <= 1'b0;
`ifdef SIGNED_POW2_DIVIDER_REMAINDER_EN
            data_q <= in_data;
            k_q    <= in_k;
`endif
            // A zero shift still spends one SHIFT cycle so the result is never same-edge.
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc    <= acc_shift;
          cnt    <= cnt_next;
          sticky <= sticky_next;
          if (cnt_next == '0) begin
            out_data  <= acc_final;
            out_valid <= 1'b1;
`ifdef SIGNED_POW2_DIVIDER_REMAINDER_EN
            out_rem   <= rem_next;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_pow2_divider_seq.sv
// Directed-vector bench for signed_pow2_divider_seq: one STEP=1 and one STEP=4 instance, N=8.
// Remainder checks are compiled in when SIGNED_POW2_DIVIDER_REMAINDER_EN is defined.
module tb_signed_pow2_divider_seq;

  localparam int N  = 8;
  localparam int SW = $clog2(N) + 1;

  logic          clk;
  logic          rst_n;
  logic          sel;
  logic          in_valid;
  logic          out_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shift;
  logic          in_mode;

  logic          in_valid_a, in_valid_b, out_ready_a, out_ready_b;
  logic          in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [N-1:0]  out_data_a, out_data_b;
  logic          in_ready_m, out_valid_m;
  logic [N-1:0]  out_data_m;

  int n_tests = 0;
  int n_fail  = 0;

  assign in_valid_a  = in_valid & ~sel;
  assign in_valid_b  = in_valid & sel;
  assign out_ready_a = out_ready & ~sel;
  assign out_ready_b = out_ready & sel;
  assign in_ready_m  = sel ? in_ready_b : in_ready_a;
  assign out_valid_m = sel ? out_valid_b : out_valid_a;
  assign out_data_m  = sel ? out_data_b : out_data_a;

`ifdef SIGNED_POW2_DIVIDER_REMAINDER_EN
  logic [N-1:0] out_rem_a, out_rem_b, out_rem_m;
  assign out_rem_m = sel ? out_rem_b : out_rem_a;
`endif

  signed_pow2_divider_seq #(.N(N), .STEP(1)) u_div1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_mode   (in_mode),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_data  (out_data_a)
`ifdef SIGNED_POW2_DIVIDER_REMAINDER_EN
    ,
    .out_rem   (out_rem_a)
`endif
  );

  signed_pow2_divider_seq #(.N(N), .STEP(4)) u_div4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_mode   (in_mode),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_data  (out_data_b)
`ifdef SIGNED_POW2_DIVIDER_REMAINDER_EN
    ,
    .out_rem   (out_rem_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction: request, latency count, result, output handshake.
  task automatic run(input logic s, input logic [N-1:0] d, input logic [SW-1:0] k,
                     input logic m, input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                     input int exp_lat, input string tag);
    int lat;
    sel      = s;
    in_data  = d;
    in_shift = k;
    in_mode  = m;
    in_valid = 1'b1;
    check({tag, "/in_ready"}, 32'(in_ready_m), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    in_shift = '0;
    in_mode  = ~m;
    lat = 0;
    while (!out_valid_m && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/data"}, 32'(out_data_m), 32'(exp_q));
`ifdef SIGNED_POW2_DIVIDER_REMAINDER_EN
    check({tag, "/rem"}, 32'(out_rem_m), 32'(exp_r));
`else
    if (exp_r != exp_r) $display("unreachable");
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, 32'(out_valid_m), 32'd0);
    check({tag, "/idle"}, 32'(in_ready_m), 32'd1);
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_mode   = 1'b0;

    #1;
    check("rst/valid_a", 32'(out_valid_a), 32'd0);
    check("rst/data_a", 32'(out_data_a), 32'd0);
    check("rst/ready_a", 32'(in_ready_a), 32'd1);
    check("rst/valid_b", 32'(out_valid_b), 32'd0);
    check("rst/ready_b", 32'(in_ready_b), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //   sel   data   k  mode  quotient rem    lat
    run(1'b0, 8'hE9, 4'd3, 1'b0, 8'hFD, 8'h01, 3, "neg23_k3_floor");
    run(1'b0, 8'hE9, 4'd3, 1'b1, 8'hFE, 8'hF9, 3, "neg23_k3_trunc");
    run(1'b0, 8'h17, 4'd3, 1'b0, 8'h02, 8'h07, 3, "pos23_k3_floor");
    run(1'b0, 8'h17, 4'd3, 1'b1, 8'h02, 8'h07, 3, "pos23_k3_trunc");
    run(1'b0, 8'h80, 4'd0, 1'b1, 8'h80, 8'h00, 1, "min_k0");
    run(1'b0, 8'h80, 4'd9, 1'b0, 8'hFF, 8'h80, 8, "min_k9_floor");
    run(1'b0, 8'h80, 4'd9, 1'b1, 8'h00, 8'h80, 8, "min_k9_trunc");
    run(1'b0, 8'h05, 4'd8, 1'b0, 8'h00, 8'h05, 8, "five_k8_floor");
    run(1'b0, 8'h05, 4'd8, 1'b1, 8'h00, 8'h05, 8, "five_k8_trunc");
    run(1'b0, 8'hF8, 4'd3, 1'b1, 8'hFF, 8'h00, 3, "neg8_k3_exact");
    run(1'b0, 8'hFF, 4'd1, 1'b0, 8'hFF, 8'h01, 1, "neg1_k1_floor");
    run(1'b0, 8'hFF, 4'd1, 1'b1, 8'h00, 8'hFF, 1, "neg1_k1_trunc");
    run(1'b1, 8'h81, 4'd7, 1'b0, 8'hFF, 8'h01, 2, "s4_neg127_k7_floor");
    run(1'b1, 8'h81, 4'd7, 1'b1, 8'h00, 8'h81, 2, "s4_neg127_k7_trunc");
    run(1'b1, 8'h80, 4'd5, 1'b1, 8'hFC, 8'h00, 2, "s4_min_k5_exact");
    run(1'b1, 8'h7F, 4'd15, 1'b0, 8'h00, 8'h7F, 2, "s4_max_k15");

    // Backpressure: result held for 5 cycles while stray requests are offered.
    sel = 1'b0;
    in_data = 8'h40; in_shift = 4'd2; in_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("bp/valid", 32'(out_valid_m), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'h33;
      in_shift = 4'd1;
      @(negedge clk);
      check("bp/hold_data", 32'(out_data_m), 32'h10);
      check("bp/hold_valid", 32'(out_valid_m), 32'd1);
      check("bp/busy", 32'(in_ready_m), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp/idle", 32'(in_ready_m), 32'd1);
    check("bp/valid_drop", 32'(out_valid_m), 32'd0);
    @(negedge clk);
    check("bp/no_stray", 32'(out_valid_m), 32'd0);

    // Reset in the middle of a shift aborts the transaction at once.
    in_data = 8'h81; in_shift = 4'd8; in_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort/busy", 32'(in_ready_m), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort/valid", 32'(out_valid_m), 32'd0);
    check("abort/data", 32'(out_data_m), 32'd0);
    check("abort/ready", 32'(in_ready_m), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort/no_result", 32'(out_valid_m), 32'd0);
    run(1'b0, 8'hE9, 4'd3, 1'b1, 8'hFE, 8'hF9, 3, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
